// File: rtl/ysyx_25020037_mem_arb_if.sv
// Bus bundle between the IFU/LSU masters, the arbiter and the shared memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ysyx_25020037_mem_arb_if;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_rsp_valid;
   logic        ifu_rsp_err;
   logic [31:0] ifu_rdata;

   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_rsp_valid;
   logic        lsu_rsp_err;
   logic [31:0] lsu_rdata;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rsp_valid;
   logic        mem_rsp_err;
   logic [31:0] mem_rdata;

   modport slave (
      input  ifu_req_valid, ifu_addr,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rdata,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, lsu_rdata,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_err, mem_rdata
   );

   modport master (
      output ifu_req_valid, ifu_addr,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rdata,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, lsu_rdata,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_req_ready, mem_rsp_valid, mem_rsp_err, mem_rdata
   );
endinterface

// File: rtl/ysyx_25020037_mem_arb.sv
// IFU/LSU arbiter onto one memory port: one outstanding transaction,
// round-robin on ties, response timeout returning an error.
module ysyx_25020037_mem_arb #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input logic clk,
   input logic rst,
   ysyx_25020037_mem_arb_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESP
   } state_e;

   state_e      state_q;
   logic        lg_lsu_q;
   logic        own_lsu_q;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;

   logic        mreq_valid_q;
   logic [31:0] maddr_q;
   logic        mwen_q;
   logic [31:0] mwdata_q;
   logic [3:0]  mwmask_q;

   logic        irv_q, ierr_q;
   logic [31:0] irdata_q;
   logic        lrv_q, lerr_q;
   logic [31:0] lrdata_q;

   logic        ifu_win, lsu_win;
   logic        busy, to_hit;
   logic        done_rsp, done_to, fin;
   logic        fin_err;
   logic [31:0] fin_data;

   // last_grant names the previous winner; the other master wins a tie
   assign ifu_win = bus.ifu_req_valid
                  & (~bus.lsu_req_valid | lg_lsu_q);
   assign lsu_win = bus.lsu_req_valid
                  & (~bus.ifu_req_valid | ~lg_lsu_q);

   assign bus.ifu_req_ready = (state_q == IDLE) & ifu_win;
   assign bus.lsu_req_ready = (state_q == IDLE) & lsu_win;

   assign busy   = (state_q == REQ) | (state_q == WAIT);
   assign cnt_d  = cnt_q + 8'd1;
   assign to_hit = (cnt_d == TIMEOUT);

   // WAIT accepts any response; REQ only with the request handshake
   assign done_rsp = bus.mem_rsp_valid
                   & ((state_q == WAIT)
                   | ((state_q == REQ) & bus.mem_req_ready));
   assign done_to  = busy & ~done_rsp & to_hit;
   assign fin      = done_rsp | done_to;
   assign fin_err  = done_rsp ? bus.mem_rsp_err : 1'b1;
   assign fin_data = done_rsp ? bus.mem_rdata : 32'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         lg_lsu_q     <= 1'b0;
         own_lsu_q    <= 1'b0;
         cnt_q        <= 8'd0;
         mreq_valid_q <= 1'b0;
         maddr_q      <= 32'h0;
         mwen_q       <= 1'b0;
         mwdata_q     <= 32'h0;
         mwmask_q     <= 4'b0;
         irv_q        <= 1'b0;
         ierr_q       <= 1'b0;
         irdata_q     <= 32'h0;
         lrv_q        <= 1'b0;
         lerr_q       <= 1'b0;
         lrdata_q     <= 32'h0;
      end else begin
         irv_q  <= 1'b0;
         ierr_q <= 1'b0;
         lrv_q  <= 1'b0;
         lerr_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (ifu_win | lsu_win) begin
                  state_q      <= REQ;
                  mreq_valid_q <= 1'b1;
                  own_lsu_q    <= lsu_win;
                  lg_lsu_q     <= lsu_win;
                  cnt_q        <= 8'd0;
                  if (lsu_win) begin
                     maddr_q  <= bus.lsu_addr;
                     mwen_q   <= bus.lsu_wen;
                     mwdata_q <= bus.lsu_wdata;
                     mwmask_q <= bus.lsu_wmask;
                  end else begin
                     maddr_q  <= bus.ifu_addr;
                     mwen_q   <= 1'b0;
                     mwdata_q <= 32'h0;
                     mwmask_q <= 4'b0;
                  end
               end
            end
            REQ, WAIT: begin
               cnt_q <= cnt_d;
               if (fin) begin
                  state_q      <= RESP;
                  mreq_valid_q <= 1'b0;
                  if (own_lsu_q) begin
                     lrv_q    <= 1'b1;
                     lerr_q   <= fin_err;
                     lrdata_q <= fin_data;
                  end else begin
                     irv_q    <= 1'b1;
                     ierr_q   <= fin_err;
                     irdata_q <= fin_data;
                  end
               end else if ((state_q == REQ) & bus.mem_req_ready) begin
                  state_q      <= WAIT;
                  mreq_valid_q <= 1'b0;
               end
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_req_valid = mreq_valid_q;
   assign bus.mem_addr      = maddr_q;
   assign bus.mem_wen       = mwen_q;
   assign bus.mem_wdata     = mwdata_q;
   assign bus.mem_wmask     = mwmask_q;

   assign bus.ifu_rsp_valid = irv_q;
   assign bus.ifu_rsp_err   = ierr_q;
   assign bus.ifu_rdata     = irdata_q;
   assign bus.lsu_rsp_valid = lrv_q;
   assign bus.lsu_rsp_err   = lerr_q;
   assign bus.lsu_rdata     = lrdata_q;

endmodule
